// File: rtl/spi_shift_engine_pkg.sv
// Shared types and helpers for the SPI-lite shift engine.
// The optional loopback port is enabled with the SPI_SHIFT_LOOPBACK_EN macro.
package spi_lite_pkg;

    localparam int SPI_DATAWIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // A zero or oversized character length means a full-width character.
    function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
        return ((len == 0) || (len > width)) ? width : len;
    endfunction

endpackage

// File: rtl/spi_shift_engine_if.sv
// Register-block side bus of the SPI shift engine: control, TX/RX words, ticks and serial lines.
interface spi_shift_engine_if
    import spi_lite_pkg::*;
#(
    parameter int DATAWIDTH = SPI_DATAWIDTH_DEF
) ();
    localparam int CNTW = $clog2(DATAWIDTH + 1);

    logic                 start_i;
    logic                 abort_i;
    logic [DATAWIDTH-1:0] tx_data_i;
    logic [CNTW-1:0]      char_len_i;
    logic                 lsb_first_i;
    logic                 shift_tick_i;
    logic                 sample_tick_i;
    logic                 sdi_i;
    logic                 sdo_o;
    logic                 busy_o;
    logic                 done_o;
    logic [DATAWIDTH-1:0] rx_data_o;

    modport slave (
        input  start_i, abort_i, tx_data_i, char_len_i, lsb_first_i,
        input  shift_tick_i, sample_tick_i, sdi_i,
        output sdo_o, busy_o, done_o, rx_data_o
    );

    modport master (
        output start_i, abort_i, tx_data_i, char_len_i, lsb_first_i,
        output shift_tick_i, sample_tick_i, sdi_i,
        input  sdo_o, busy_o, done_o, rx_data_o
    );

endinterface

// File: rtl/spi_shift_engine_bit_counter.sv
// Received-bit counter: cleared on transfer start, advanced per sample, flags the final sample.
module spi_bit_counter #(
    parameter int CNTW = 4
) (
    input  logic            clk_i,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            inc_i,
    input  logic [CNTW-1:0] len_i,
    output logic [CNTW-1:0] cnt_o,
    output logic            last_o
);
    logic [CNTW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i)
            cnt_d = cnt_q + CNTW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    // True while the next sample is the L-th one.
    assign last_o = (cnt_q == len_i - CNTW'(1));

endmodule

// File: rtl/spi_shift_engine.sv
// Full-duplex SPI shift engine: serialises a TX word and deserialises sdi_i over a runtime length.
// Defining SPI_SHIFT_LOOPBACK_EN adds loopback_i, which samples the internal sdo_o instead of sdi_i.
module spi_shift_engine
    import spi_lite_pkg::*;
#(
    parameter int DATAWIDTH = SPI_DATAWIDTH_DEF
) (
    input  logic clk_i,
    input  logic rst_n,
`ifdef SPI_SHIFT_LOOPBACK_EN
    input  logic loopback_i,
`endif
    spi_shift_engine_if.slave bus
);
    localparam int CNTW = $clog2(DATAWIDTH + 1);

    state_e               state_q, state_d;
    logic [DATAWIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [DATAWIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [DATAWIDTH-1:0] rx_data_q, rx_data_d;
    logic [CNTW-1:0]      len_q, len_d;
    logic                 lsb_q, lsb_d;

    logic                 start_acc, shift_en, sample_en, last_sample, sample_bit, sdo;
    logic [CNTW-1:0]      bit_cnt;
    logic [DATAWIDTH-1:0] tx_msb_win;

    assign start_acc = (state_q == ST_IDLE)  && bus.start_i       && !bus.abort_i;
    assign shift_en  = (state_q == ST_SHIFT) && bus.shift_tick_i  && !bus.abort_i;
    assign sample_en = (state_q == ST_SHIFT) && bus.sample_tick_i && !bus.abort_i;

`ifdef SPI_SHIFT_LOOPBACK_EN
    assign sample_bit = loopback_i ? sdo : bus.sdi_i;
`else
    assign sample_bit = bus.sdi_i;
`endif

    spi_bit_counter #(.CNTW(CNTW)) u_bit_counter (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .clr_i  (start_acc),
        .inc_i  (sample_en),
        .len_i  (len_q),
        .cnt_o  (bit_cnt),
        .last_o (last_sample)
    );

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            len_q     <= '0;
            lsb_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            len_q     <= len_d;
            lsb_q     <= lsb_d;
        end
    end

    // Abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (bus.abort_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start_acc) state_d = ST_SHIFT;
                ST_SHIFT: if (sample_en && last_sample) state_d = ST_DONE;
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        len_d     = len_q;
        lsb_d     = lsb_q;
        if (start_acc) begin
            tx_sr_d = bus.tx_data_i;
            len_d   = CNTW'(eff_len(32'(bus.char_len_i), DATAWIDTH));
            lsb_d   = bus.lsb_first_i;
            rx_sr_d = '0;
        end
        if (shift_en)
            tx_sr_d = lsb_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
        // LSB-first places each bit at its count position; the register was cleared at start.
        if (sample_en)
            rx_sr_d = lsb_q ? (rx_sr_q | (DATAWIDTH'(sample_bit) << bit_cnt))
                            : {rx_sr_q[DATAWIDTH-2:0], sample_bit};
        // The received word is published while leaving DONE and held until the next completion.
        if ((state_q == ST_DONE) && !bus.abort_i)
            rx_data_d = rx_sr_q;
    end

    always_comb begin
        tx_msb_win = tx_sr_q >> (len_q - CNTW'(1));
        sdo        = 1'b0;
        if (state_q == ST_SHIFT)
            sdo = lsb_q ? tx_sr_q[0] : tx_msb_win[0];
        bus.sdo_o     = sdo;
        bus.busy_o    = (state_q == ST_SHIFT);
        bus.done_o    = (state_q == ST_DONE);
        bus.rx_data_o = rx_data_q;
    end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine with a bit-list reference model checked every cycle.
module tb_spi_shift_engine;
    import spi_lite_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic tie = 1'b0;
    logic sdi_drv = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;

    spi_shift_engine_if #(.DATAWIDTH(W)) bus ();

    assign bus.sdi_i = tie ? bus.sdo_o : sdi_drv;

    spi_shift_engine #(.DATAWIDTH(W)) dut (
        .clk_i      (clk),
        .rst_n      (rst_n),
`ifdef SPI_SHIFT_LOOPBACK_EN
        .loopback_i (1'b0),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: transfer described as bit lists and counts of ticks.
    int         m_phase;      // 0 idle, 1 shifting, 2 done
    int         m_len, m_shifts, m_samples;
    bit         m_lsb;
    logic [W-1:0] m_tx, m_rx_data, m_result;
    bit         m_rx_bits [W];

    function automatic bit m_sdo();
        if (m_phase != 1) return 1'b0;
        if (m_lsb) return (m_shifts < W) ? m_tx[m_shifts] : 1'b0;
        return (m_shifts < m_len) ? m_tx[m_len-1-m_shifts] : 1'b0;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_len = 0; m_shifts = 0; m_samples = 0; m_lsb = 0;
        m_tx = '0; m_rx_data = '0; m_result = '0;
    endtask

    task automatic model_step();
        bit sd;
        int cl;
        sd = tie ? m_sdo() : sdi_drv;
        if (bus.abort_i) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (bus.start_i) begin
                cl = int'(bus.char_len_i);
                m_len = (cl == 0 || cl > W) ? W : cl;
                m_lsb = bus.lsb_first_i;
                m_tx = bus.tx_data_i;
                m_shifts = 0; m_samples = 0;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (bus.sample_tick_i) begin
                m_rx_bits[m_samples] = sd;
                m_samples++;
            end
            if (bus.shift_tick_i) m_shifts++;
            if (m_samples == m_len) begin
                m_result = '0;
                for (int i = 0; i < m_len; i++)
                    if (m_rx_bits[i])
                        m_result = m_result + (m_lsb ? (W'(1) << i) : (W'(1) << (m_len-1-i)));
                m_phase = 2;
            end
        end else begin
            m_rx_data = m_result;
            m_phase = 0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) model_reset();
        chk("cyc_busy", bus.busy_o, (m_phase == 1));
        chk("cyc_done", bus.done_o, (m_phase == 2));
        chk("cyc_sdo", bus.sdo_o, m_sdo());
        chk("cyc_rx_data", bus.rx_data_o, m_rx_data);
        if (bus.done_o) done_cnt++;
        if (rst_n) model_step();
    end

    // Stimulus: all inputs change 1 time unit after a rising edge.
    bit seq [16];
    int n;

    task automatic start_xfer(input logic [W-1:0] tx, input logic [3:0] cl, input bit lsb);
        bus.start_i = 1'b1; bus.tx_data_i = tx; bus.char_len_i = cl; bus.lsb_first_i = lsb;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
    endtask

    task automatic pair(input bit sd);
        seq[n] = bus.sdo_o; n++;
        bus.shift_tick_i = 1'b1; bus.sample_tick_i = 1'b1; sdi_drv = sd;
        @(posedge clk); #1;
        bus.shift_tick_i = 1'b0; bus.sample_tick_i = 1'b0;
    endtask

    task automatic sep(input bit sd);
        seq[n] = bus.sdo_o; n++;
        bus.sample_tick_i = 1'b1; sdi_drv = sd;
        @(posedge clk); #1;
        bus.sample_tick_i = 1'b0; bus.shift_tick_i = 1'b1;
        @(posedge clk); #1;
        bus.shift_tick_i = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic chk_seq(input string nm, input logic [W-1:0] bits, input int len);
        for (int i = 0; i < len; i++) chk(nm, seq[i], bits[len-1-i]);
    endtask

    initial begin
        logic [W-1:0] v;
        bus.start_i = 0; bus.abort_i = 0; bus.tx_data_i = '0; bus.char_len_i = '0;
        bus.lsb_first_i = 0; bus.shift_tick_i = 0; bus.sample_tick_i = 0;
        #1 rst_n = 1'b0;
        idle(3);
        chk("rst_sdo", bus.sdo_o, 0); chk("rst_busy", bus.busy_o, 0);
        chk("rst_done", bus.done_o, 0); chk("rst_rx", bus.rx_data_o, 0);
        rst_n = 1'b1;
        idle(2);

        // 0xA5 MSB-first, looped back; start during DONE must be ignored
        tie = 1; done_cnt = 0; n = 0;
        start_xfer(8'hA5, 4'd8, 1'b0);
        chk("t1_busy_first", bus.busy_o, 1);
        for (int i = 0; i < 8; i++) pair(1'b0);
        chk("t1_done_lat", bus.done_o, 1);
        bus.start_i = 1'b1; bus.tx_data_i = 8'h00;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        chk("t1_rx", bus.rx_data_o, 8'hA5);
        chk("t1_start_in_done", bus.busy_o, 0);
        chk_seq("t1_sdo_seq", 8'b1010_0101, 8);
        idle(2);
        chk("t1_done_cnt", done_cnt, 1);

        // L=5 LSB-first, sample and shift on separate ticks
        tie = 0; done_cnt = 0; n = 0;
        start_xfer(8'h13, 4'd5, 1'b1);
        v = 8'b0000_1101; // sdi order 1,0,1,1,0
        sep(1'b1); sep(1'b0); sep(1'b1); sep(1'b1); sep(1'b0);
        chk("t2_rx", bus.rx_data_o, 8'h0D);
        chk("t2_rx_upper", bus.rx_data_o[7:5], 3'b000);
        chk_seq("t2_sdo_seq", 8'b0001_1001, 5);
        chk("t2_rx_model", bus.rx_data_o, v);
        idle(2);
        chk("t2_done_cnt", done_cnt, 1);

        // Length 0 and 12 both mean 8 bits
        tie = 1; done_cnt = 0; n = 0;
        start_xfer(8'h3C, 4'd0, 1'b0);
        for (int i = 0; i < 7; i++) pair(1'b0);
        chk("t3a_busy_after7", bus.busy_o, 1);
        pair(1'b0);
        chk("t3a_done", bus.done_o, 1);
        idle(1);
        chk("t3a_rx", bus.rx_data_o, 8'h3C);
        n = 0;
        start_xfer(8'h3C, 4'd12, 1'b1);
        for (int i = 0; i < 7; i++) pair(1'b0);
        chk("t3b_busy_after7", bus.busy_o, 1);
        pair(1'b0);
        chk("t3b_done", bus.done_o, 1);
        idle(1);
        chk("t3b_rx", bus.rx_data_o, 8'h3C);
        chk_seq("t3b_sdo_seq", 8'b0011_1100, 8);
        idle(2);
        chk("t3_done_cnt", done_cnt, 2);

        // Prime rx_data=0x5A, then abort a 0xFF transfer after 3 samples
        tie = 0; n = 0;
        start_xfer(8'h00, 4'd8, 1'b0);
        v = 8'h5A;
        for (int i = 7; i >= 0; i--) pair(v[i]);
        idle(2);
        chk("t4_prior_rx", bus.rx_data_o, 8'h5A);
        done_cnt = 0;
        start_xfer(8'hFF, 4'd8, 1'b0);
        pair(1'b1); pair(1'b1); pair(1'b1);
        bus.abort_i = 1'b1;
        @(posedge clk); #1;
        bus.abort_i = 1'b0;
        chk("t4_busy", bus.busy_o, 0);
        chk("t4_sdo", bus.sdo_o, 0);
        chk("t4_done", bus.done_o, 0);
        chk("t4_rx_kept", bus.rx_data_o, 8'h5A);
        idle(4);
        chk("t4_done_cnt", done_cnt, 0);

        // start with 0x00 mid-transfer of 0xC3 is ignored
        tie = 1; done_cnt = 0; n = 0;
        start_xfer(8'hC3, 4'd8, 1'b0);
        pair(1'b0); pair(1'b0); pair(1'b0);
        bus.start_i = 1'b1; bus.tx_data_i = 8'h00;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        for (int i = 0; i < 5; i++) pair(1'b0);
        idle(1);
        chk_seq("t5_sdo_seq", 8'b1100_0011, 8);
        chk("t5_rx", bus.rx_data_o, 8'hC3);
        idle(2);
        chk("t5_done_cnt", done_cnt, 1);

        // Asynchronous reset mid-transfer
        done_cnt = 0; n = 0;
        start_xfer(8'hA5, 4'd8, 1'b0);
        for (int i = 0; i < 4; i++) pair(1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_sdo", bus.sdo_o, 0); chk("t6_busy", bus.busy_o, 0);
        chk("t6_done", bus.done_o, 0); chk("t6_rx", bus.rx_data_o, 0);
        idle(2);
        rst_n = 1'b1;
        idle(6);
        chk("t6_done_cnt", done_cnt, 0);
        chk("t6_busy_after", bus.busy_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
- Parametrised full-duplex SPI shift engine for the APB SPI-lite datapath.
- Loads a TX word and serialises it MSB- or LSB-first over a runtime character length; simultaneously deserialises the receive line.
- Driven by shift/sample tick strobes from the SCLK generator; reports busy/done to the APB register block.
- Successor to the fixed load/shift serialiser: adds RX path, bit counting, variable length, abort and a done handshake.

Parameters:
- DATAWIDTH, 8, maximum character width in bits (>=2).
- CNTW, $clog2(DATAWIDTH+1), bit-counter/length width (localparam, derived).

Ports:
- clk_i  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start_i  in  1  begin transfer (accepted only in IDLE).
- abort_i  in  1  cancel transfer, return to IDLE.
- tx_data_i  in  DATAWIDTH  word to transmit, right-justified.
- char_len_i  in  CNTW  bits per character; 0 or >DATAWIDTH means DATAWIDTH.
- lsb_first_i  in  1  1 = LSB first, 0 = MSB first.
- shift_tick_i  in  1  advance TX bit (one-cycle strobe).
- sample_tick_i  in  1  capture sdi_i (one-cycle strobe).
- sdi_i  in  1  serial data in (MISO).
- sdo_o  out  1  serial data out (MOSI).
- busy_o  out  1  transfer in progress.
- done_o  out  1  one-cycle completion pulse.
- rx_data_o  out  DATAWIDTH  last received word, right-justified.

Behaviour:
- Reset: state IDLE; sdo_o=0, busy_o=0, done_o=0, rx_data_o=0; all internal registers 0.
- States: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - sdo_o=0.
  - start_i=1 latches tx_data_i, the effective length L, and lsb_first_i; clears rx shift register and bit_cnt; enters SHIFT next cycle.
- SHIFT:
  - busy_o=1 from the cycle after start.
  - sdo_o = tx_sr[0] (LSB-first) or tx_sr[L-1] (MSB-first); first bit is valid in the first SHIFT cycle.
- shift_tick_i in SHIFT: tx_sr shifts right (LSB-first) or left (MSB-first), zero-filled.
- sample_tick_i in SHIFT:
  - MSB-first: rx_sr <= {rx_sr[W-2:0], sdi_i}.
  - LSB-first: rx_sr[bit_cnt] <= sdi_i.
  - bit_cnt increments on each sample.
- Both ticks in the same cycle: both actions apply; the sample uses sdi_i, independent of the shift.
- Completion: the sample that makes bit_cnt==L moves to DONE next cycle.
  - Result: bits [L-1:0] hold the received data, upper bits 0. First received bit lands at bit L-1 (MSB-first) or bit 0 (LSB-first).
- DONE (one cycle):
  - done_o=1, rx_data_o <= rx_sr, busy_o=0, sdo_o=0.
  - Returns to IDLE.
  - start_i during DONE is ignored.
- Latency: done_o asserts exactly one cycle after the L-th sample tick.
- Ticks are ignored in IDLE and DONE; shift ticks after the final sample are ignored.
- start_i while busy: ignored; latched values unchanged.
- abort_i:
  - Highest priority over start_i and ticks, in any state.
  - Next cycle: IDLE, busy_o=0, sdo_o=0.
  - No done_o; rx_data_o keeps its previous value.
- Asynchronous reset mid-transfer: immediate return to reset values; no done_o.

Optional Feature:
- Macro: SPI_SHIFT_LOOPBACK_EN.
- Defined: adds input port loopback_i (1 bit). When 1, the sampled bit is the internal sdo_o value instead of sdi_i; sdo_o still drives the pin.
- Undefined: port absent; sampling always uses sdi_i.

Decomposition:
- Package spi_lite_pkg holds:
  - state enum (ST_IDLE, ST_SHIFT, ST_DONE);
  - SPI_DATAWIDTH_DEF=8;
  - effective-length function (maps 0 or >DATAWIDTH to DATAWIDTH).
- One natural sub-module: spi_bit_counter (clear, increment-on-sample, terminal-count compare against L).

Test Plan:
- W=8, L=8, MSB-first, tx=0xA5, sdi tied to sdo, 8 shift+sample tick pairs -> sdo sequence 1,0,1,0,0,1,0,1; done_o pulses once, 1 cycle after 8th sample; rx_data_o=0xA5.
- L=5, LSB-first, tx=0x13, sdi pattern 1,0,1,1,0 -> sdo 1,1,0,0,1; rx_data_o=0x0D; bits[7:5]=0.
- char_len_i=0 and char_len_i=12, tx=0x3C loopback -> both run 8 bits; rx_data_o=0x3C.
- Abort after 3 samples of a 0xFF transfer, prior rx_data_o=0x5A -> busy_o=0 next cycle; no done_o; rx_data_o stays 0x5A; sdo_o=0.
- start_i with tx=0x00 pulsed mid-transfer of 0xC3 -> ignored; transfer completes with 0xC3 on sdo.
- rst_n asserted mid-transfer -> all outputs 0 immediately; no done_o after release.
